// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs, EX/MEM latch outputs and redirect of the execute stage.
// Modports: master (upstream/driver side), slave (ex_stage side).
interface ex_stage_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int RA_W   = 5
);
  logic [3:0]        alu_control;
  logic              id_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] id_rs1_data;
  logic [DATA_W-1:0] id_rs2_data;
  logic [DATA_W-1:0] id_imm;
  logic              id_alu_src;
  logic [PC_W-1:0]   id_pc;
  logic [RA_W-1:0]   id_rs1;
  logic [RA_W-1:0]   id_rs2;
  logic [RA_W-1:0]   id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_branch;
  logic              mem_stall;
  logic              flush;
  logic              exmem_valid;
  logic [DATA_W-1:0] exmem_result;
  logic [DATA_W-1:0] exmem_store_data;
  logic [RA_W-1:0]   exmem_rd;
  logic              exmem_reg_write;
  logic              exmem_mem_read;
  logic              exmem_mem_write;
  logic              exmem_zero;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;

  modport master (
    output alu_control, id_valid,
    output id_rs1_data, id_rs2_data, id_imm,
    output id_alu_src, id_pc,
    output id_rs1, id_rs2, id_rd,
    output id_reg_write, id_mem_read,
    output id_mem_write, id_branch,
    output mem_stall, flush,
    input  ex_ready, exmem_valid,
    input  exmem_result, exmem_store_data,
    input  exmem_rd, exmem_reg_write,
    input  exmem_mem_read, exmem_mem_write,
    input  exmem_zero, redirect, redirect_pc
  );

  modport slave (
    input  alu_control, id_valid,
    input  id_rs1_data, id_rs2_data, id_imm,
    input  id_alu_src, id_pc,
    input  id_rs1, id_rs2, id_rd,
    input  id_reg_write, id_mem_read,
    input  id_mem_write, id_branch,
    input  mem_stall, flush,
    output ex_ready, exmem_valid,
    output exmem_result, exmem_store_data,
    output exmem_rd, exmem_reg_write,
    output exmem_mem_read, exmem_mem_write,
    output exmem_zero, redirect, redirect_pc
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: ALU, branch/jump resolution and EX/MEM latch with squash shadow.
// Ports: clk, rst_n (async low), io (ex_stage_if.slave). Option: EX_FORWARD_EN.
module ex_stage #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int RA_W   = 5
) (
  input logic       clk,
  input logic       rst_n,
  ex_stage_if.slave io
);
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_JUMP = 4'b1000;

  typedef enum logic {RUN, SQUASH} state_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store;
    logic [RA_W-1:0]   rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              zero;
  } exmem_t;

  state_t            state_q, state_d;
  exmem_t            lat_q, lat_d;
  logic              redir_q, redir_d;
  logic [PC_W-1:0]   rpc_q, rpc_d;
  logic [DATA_W-1:0] a, rs2v, b;
  logic [DATA_W-1:0] diff, res;
  logic [PC_W-1:0]   pc_inc, tgt;
  logic              hold, accept, taken;

  assign io.ex_ready = !lat_q.valid | !io.mem_stall;
  assign hold        = lat_q.valid & io.mem_stall;
  assign accept      = io.id_valid & io.ex_ready;

`ifdef EX_FORWARD_EN
  logic fwd_ok, fwd_a, fwd_b;
  // Loads are excluded: their data is not known until MEM.
  assign fwd_ok = lat_q.valid & lat_q.reg_write
                & !lat_q.mem_read & (lat_q.rd != '0);
  assign fwd_a  = fwd_ok & (lat_q.rd == io.id_rs1);
  assign fwd_b  = fwd_ok & (lat_q.rd == io.id_rs2);
  assign a      = fwd_a ? lat_q.result : io.id_rs1_data;
  assign rs2v   = fwd_b ? lat_q.result : io.id_rs2_data;
`else
  logic unused_rs;
  assign unused_rs = ^{io.id_rs1, io.id_rs2};
  assign a         = io.id_rs1_data;
  assign rs2v      = io.id_rs2_data;
`endif

  assign b      = io.id_alu_src ? io.id_imm : rs2v;
  assign diff   = a - b;
  assign pc_inc = io.id_pc + PC_W'(1);
  assign tgt    = io.id_pc + PC_W'(signed'(io.id_imm));

  always_comb begin
    res = '0;
    unique case (io.alu_control)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD:  res = a + b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_SUB:  res = diff;
      OP_JUMP: res = DATA_W'(pc_inc);
      default: res = '0;
    endcase
  end

  assign taken = (io.id_branch & (io.alu_control == OP_SUB)
                 & (diff == '0))
               | (io.alu_control == OP_JUMP);

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    redir_d = 1'b0;
    rpc_d   = rpc_q;
    if (io.flush) begin
      lat_d.valid     = 1'b0;
      lat_d.reg_write = 1'b0;
      lat_d.mem_read  = 1'b0;
      lat_d.mem_write = 1'b0;
      lat_d.zero      = 1'b0;
      state_d         = RUN;
    end else if (hold) begin
      lat_d = lat_q;
    end else if (accept && state_q == RUN) begin
      lat_d.valid     = 1'b1;
      lat_d.result    = res;
      lat_d.store     = rs2v;
      lat_d.rd        = io.id_rd;
      lat_d.reg_write = io.id_reg_write;
      lat_d.mem_read  = io.id_mem_read;
      lat_d.mem_write = io.id_mem_write;
      lat_d.zero      = (res == '0);
      redir_d         = taken;
      if (taken) begin
        rpc_d   = tgt;
        state_d = SQUASH;
      end
    end else begin
      // Bubble, or the shadow slot behind a taken redirect.
      lat_d.valid     = 1'b0;
      lat_d.reg_write = 1'b0;
      lat_d.mem_read  = 1'b0;
      lat_d.mem_write = 1'b0;
      lat_d.zero      = 1'b0;
      if (accept) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      lat_q   <= '0;
      redir_q <= 1'b0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      redir_q <= redir_d;
      rpc_q   <= rpc_d;
    end
  end

  assign io.exmem_valid      = lat_q.valid;
  assign io.exmem_result     = lat_q.result;
  assign io.exmem_store_data = lat_q.store;
  assign io.exmem_rd         = lat_q.rd;
  assign io.exmem_reg_write  = lat_q.reg_write;
  assign io.exmem_mem_read   = lat_q.mem_read;
  assign io.exmem_mem_write  = lat_q.mem_write;
  assign io.exmem_zero       = lat_q.zero;
  assign io.redirect         = redir_q;
  assign io.redirect_pc      = rpc_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors for ex_stage with a queue scoreboard.
// Stimulus pushes expected EX/MEM contents; a monitor pops on each accept.
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_stage_if #(.DATA_W(8), .PC_W(8), .RA_W(5)) io();

  ex_stage #(.DATA_W(8), .PC_W(8), .RA_W(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io(io)
  );

  localparam logic [3:0] AND_ = 4'b0000;
  localparam logic [3:0] OR_  = 4'b0001;
  localparam logic [3:0] ADD_ = 4'b0010;
  localparam logic [3:0] XOR_ = 4'b0011;
  localparam logic [3:0] NOT_ = 4'b0100;
  localparam logic [3:0] SUB_ = 4'b0110;
  localparam logic [3:0] JMP_ = 4'b1000;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, imm, pc;
    logic       src;
    logic [4:0] rs1, rs2, rd;
    logic [3:0] ctl;
  } ins_t;

  typedef struct {
    logic       v;
    logic [7:0] res;
    logic       z;
    logic [4:0] rd;
    logic [2:0] ctl;
    logic [7:0] st;
    logic       redir;
    logic [7:0] rpc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // ctl = {reg_write, mem_read, mem_write, branch}
  function automatic ins_t mk(input logic [3:0] op,
                              input logic [7:0] a, b, imm,
                              input logic src,
                              input logic [7:0] pc,
                              input logic [4:0] rd,
                              input logic [3:0] ctl);
    ins_t i;
    i.op = op; i.a = a; i.b = b; i.imm = imm;
    i.src = src; i.pc = pc; i.rd = rd; i.ctl = ctl;
    i.rs1 = 5'd0; i.rs2 = 5'd0;
    return i;
  endfunction

  // ctl = {reg_write, mem_read, mem_write}
  function automatic exp_t ex(input logic v,
                              input logic [7:0] res,
                              input logic z,
                              input logic [4:0] rd,
                              input logic [2:0] ctl,
                              input logic [7:0] st,
                              input logic redir,
                              input logic [7:0] rpc);
    exp_t e;
    e.v = v; e.res = res; e.z = z; e.rd = rd;
    e.ctl = ctl; e.st = st; e.redir = redir; e.rpc = rpc;
    return e;
  endfunction

  function automatic exp_t bub();
    return ex(1'b0, 8'h00, 1'b0, 5'd0, 3'b000,
              8'h00, 1'b0, 8'h00);
  endfunction

  task automatic apply(input ins_t i);
    io.alu_control  = i.op;
    io.id_rs1_data  = i.a;
    io.id_rs2_data  = i.b;
    io.id_imm       = i.imm;
    io.id_alu_src   = i.src;
    io.id_pc        = i.pc;
    io.id_rs1       = i.rs1;
    io.id_rs2       = i.rs2;
    io.id_rd        = i.rd;
    io.id_reg_write = i.ctl[3];
    io.id_mem_read  = i.ctl[2];
    io.id_mem_write = i.ctl[1];
    io.id_branch    = i.ctl[0];
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic drive(input ins_t i, input exp_t e);
    int n;
    n = 0;
    apply(i);
    io.id_valid = 1'b1;
    sb.push_back(e);
    #3;
    while (!io.ex_ready && n < 20) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (!io.ex_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ex_ready stuck 0");
    end
    @(negedge clk);
    io.id_valid = 1'b0;
  endtask

  // Monitor: compare on every accepting edge, else expect no redirect.
  initial begin : monitor
    exp_t e;
    logic acc, live;
    forever begin
      @(negedge clk);
      #3;
      live = rst_n;
      acc  = io.id_valid & io.ex_ready & !io.flush;
      @(posedge clk);
      #1;
      if (!live || !rst_n) continue;
      if (acc) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: accept with no expected entry");
        end else begin
          e = sb.pop_front();
          if (e.v) begin
            chk("exmem_entry",
                32'({io.exmem_valid, io.exmem_result,
                     io.exmem_zero, io.exmem_rd,
                     io.exmem_reg_write, io.exmem_mem_read,
                     io.exmem_mem_write, io.exmem_store_data,
                     io.redirect}),
                32'({e.v, e.res, e.z, e.rd, e.ctl,
                     e.st, e.redir}));
          end else begin
            chk("squash_entry",
                32'({io.exmem_valid, io.exmem_reg_write,
                     io.exmem_mem_read, io.exmem_mem_write,
                     io.redirect}),
                32'(5'b00000));
          end
          if (e.redir) begin
            chk("redirect_pc", 32'(io.redirect_pc), 32'(e.rpc));
          end
        end
      end else begin
        chk("no_redirect", 32'(io.redirect), 32'(1'b0));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    ins_t i;
    rst_n = 1'b0;
    io.id_valid  = 1'b0;
    io.mem_stall = 1'b0;
    io.flush     = 1'b0;
    apply(mk(ADD_, 8'h00, 8'h00, 8'h00, 1'b0,
             8'h00, 5'd0, 4'b0000));
    #12;
    chk("rst_valid", 32'(io.exmem_valid), 32'(1'b0));
    chk("rst_result", 32'(io.exmem_result), 32'(8'h00));
    chk("rst_redirect", 32'(io.redirect), 32'(1'b0));
    chk("rst_rpc", 32'(io.redirect_pc), 32'(8'h00));
    chk("rst_ready", 32'(io.ex_ready), 32'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    drive(mk(ADD_, 8'hF0, 8'h20, 8'h00, 1'b0, 8'h00, 5'd1, 4'b1000),
          ex(1'b1, 8'h10, 1'b0, 5'd1, 3'b100, 8'h20, 1'b0, 8'h00));
    drive(mk(SUB_, 8'h05, 8'h05, 8'hFC, 1'b0, 8'h10, 5'd0, 4'b0001),
          ex(1'b1, 8'h00, 1'b1, 5'd0, 3'b000, 8'h05, 1'b1, 8'h0C));
    drive(mk(AND_, 8'h0F, 8'h3C, 8'h00, 1'b0, 8'h12, 5'd2, 4'b1000),
          bub());
    drive(mk(AND_, 8'h0F, 8'h3C, 8'h00, 1'b0, 8'h12, 5'd2, 4'b1000),
          ex(1'b1, 8'h0C, 1'b0, 5'd2, 3'b100, 8'h3C, 1'b0, 8'h00));
    drive(mk(JMP_, 8'h00, 8'h00, 8'h02, 1'b0, 8'h3F, 5'd5, 4'b1000),
          ex(1'b1, 8'h40, 1'b0, 5'd5, 3'b100, 8'h00, 1'b1, 8'h41));
    drive(mk(OR_, 8'h50, 8'h77, 8'h0A, 1'b1, 8'h00, 5'd6, 4'b1000),
          bub());
    drive(mk(OR_, 8'h50, 8'h77, 8'h0A, 1'b1, 8'h00, 5'd6, 4'b1000),
          ex(1'b1, 8'h5A, 1'b0, 5'd6, 3'b100, 8'h77, 1'b0, 8'h00));
    drive(mk(NOT_, 8'h3C, 8'hFF, 8'h00, 1'b0, 8'h00, 5'd7, 4'b1000),
          ex(1'b1, 8'hC3, 1'b0, 5'd7, 3'b100, 8'hFF, 1'b0, 8'h00));
    drive(mk(SUB_, 8'h07, 8'h05, 8'h04, 1'b0, 8'h20, 5'd8, 4'b0001),
          ex(1'b1, 8'h02, 1'b0, 5'd8, 3'b000, 8'h05, 1'b0, 8'h00));
    drive(mk(ADD_, 8'hFF, 8'h01, 8'h00, 1'b0, 8'h00, 5'd9, 4'b1000),
          ex(1'b1, 8'h00, 1'b1, 5'd9, 3'b100, 8'h01, 1'b0, 8'h00));
    drive(mk(SUB_, 8'h09, 8'h09, 8'h00, 1'b0, 8'h00, 5'd10, 4'b1000),
          ex(1'b1, 8'h00, 1'b1, 5'd10, 3'b100, 8'h09, 1'b0, 8'h00));
    drive(mk(4'b0101, 8'h12, 8'h34, 8'h00, 1'b0, 8'h00, 5'd11, 4'b1000),
          ex(1'b1, 8'h00, 1'b1, 5'd11, 3'b100, 8'h34, 1'b0, 8'h00));
    drive(mk(4'b1111, 8'h05, 8'h05, 8'h04, 1'b0, 8'h00, 5'd0, 4'b0001),
          ex(1'b1, 8'h00, 1'b1, 5'd0, 3'b000, 8'h05, 1'b0, 8'h00));
    drive(mk(ADD_, 8'h10, 8'h99, 8'h04, 1'b1, 8'h00, 5'd3, 4'b1100),
          ex(1'b1, 8'h14, 1'b0, 5'd3, 3'b110, 8'h99, 1'b0, 8'h00));
    drive(mk(ADD_, 8'h10, 8'h5A, 8'h08, 1'b1, 8'h00, 5'd0, 4'b0010),
          ex(1'b1, 8'h18, 1'b0, 5'd0, 3'b001, 8'h5A, 1'b0, 8'h00));

    // Stall: entry held for 3 cycles while a new op waits.
    drive(mk(ADD_, 8'h01, 8'h01, 8'h00, 1'b0, 8'h00, 5'd12, 4'b1000),
          ex(1'b1, 8'h02, 1'b0, 5'd12, 3'b100, 8'h01, 1'b0, 8'h00));
    io.mem_stall = 1'b1;
    apply(mk(XOR_, 8'h11, 8'h22, 8'h00, 1'b0, 8'h00, 5'd13, 4'b1000));
    io.id_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("stall_ready", 32'(io.ex_ready), 32'(1'b0));
      chk("stall_result", 32'(io.exmem_result), 32'(8'h02));
      chk("stall_valid", 32'(io.exmem_valid), 32'(1'b1));
      @(negedge clk);
    end
    io.mem_stall = 1'b0;
    drive(mk(XOR_, 8'h11, 8'h22, 8'h00, 1'b0, 8'h00, 5'd13, 4'b1000),
          ex(1'b1, 8'h33, 1'b0, 5'd13, 3'b100, 8'h22, 1'b0, 8'h00));

    // Flush during SQUASH with mem_stall: flush wins, state back to RUN.
    drive(mk(JMP_, 8'h00, 8'h00, 8'h10, 1'b0, 8'h20, 5'd1, 4'b1000),
          ex(1'b1, 8'h21, 1'b0, 5'd1, 3'b100, 8'h00, 1'b1, 8'h30));
    io.mem_stall = 1'b1;
    io.flush     = 1'b1;
    apply(mk(AND_, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h00, 5'd7, 4'b1000));
    io.id_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_valid", 32'(io.exmem_valid), 32'(1'b0));
    chk("flush_rw", 32'(io.exmem_reg_write), 32'(1'b0));
    chk("flush_redirect", 32'(io.redirect), 32'(1'b0));
    @(negedge clk);
    io.flush     = 1'b0;
    io.mem_stall = 1'b0;
    io.id_valid  = 1'b0;
    drive(mk(XOR_, 8'hAA, 8'h0F, 8'h00, 1'b0, 8'h00, 5'd2, 4'b1000),
          ex(1'b1, 8'hA5, 1'b0, 5'd2, 3'b100, 8'h0F, 1'b0, 8'h00));

    // Reset in the redirect cycle: everything clears, no squash after.
    drive(mk(SUB_, 8'h07, 8'h07, 8'h08, 1'b0, 8'h40, 5'd0, 4'b0001),
          ex(1'b1, 8'h00, 1'b1, 5'd0, 3'b000, 8'h07, 1'b1, 8'h48));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(io.exmem_valid), 32'(1'b0));
    chk("mid_rst_redirect", 32'(io.redirect), 32'(1'b0));
    chk("mid_rst_rpc", 32'(io.redirect_pc), 32'(8'h00));
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(ADD_, 8'h02, 8'h03, 8'h00, 1'b0, 8'h00, 5'd4, 4'b1000),
          ex(1'b1, 8'h05, 1'b0, 5'd4, 3'b100, 8'h03, 1'b0, 8'h00));

    // Back-to-back dependency on x3 with stale operand data.
    drive(mk(ADD_, 8'h01, 8'h02, 8'h00, 1'b0, 8'h00, 5'd3, 4'b1000),
          ex(1'b1, 8'h03, 1'b0, 5'd3, 3'b100, 8'h02, 1'b0, 8'h00));
    i = mk(ADD_, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 5'd4, 4'b1000);
    i.rs1 = 5'd3;
    i.rs2 = 5'd3;
`ifdef EX_FORWARD_EN
    drive(i, ex(1'b1, 8'h06, 1'b0, 5'd4, 3'b100, 8'h03, 1'b0, 8'h00));
`else
    drive(i, ex(1'b1, 8'h00, 1'b1, 5'd4, 3'b100, 8'h00, 1'b0, 8'h00));
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 8-bit pipelined RISC-V core, directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU control code plus ID/EX operands, and computes the result, zero flag, branch/jump resolution and link address.
- Registers everything into the EX/MEM pipeline latch, with valid/stall/flush handling and a one-instruction squash shadow after a taken redirect.

Parameters:
- DATA_W, 8, datapath/operand width
- PC_W, 8, program counter width
- RA_W, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_control  in  4  op code: AND=0000, OR=0001, ADD=0010, XOR=0011, NOT=0100, SUB=0110, JUMP=1000
- id_valid  in  1  ID/EX holds a valid instruction
- ex_ready  out  1  stage can accept id_* this cycle
- id_rs1_data  in  DATA_W  operand A
- id_rs2_data  in  DATA_W  operand B / store data
- id_imm  in  DATA_W  sign-extended immediate
- id_alu_src  in  1  1: B = id_imm, 0: B = id_rs2_data
- id_pc  in  PC_W  instruction PC
- id_rs1, id_rs2, id_rd  in  RA_W  register addresses
- id_reg_write, id_mem_read, id_mem_write, id_branch  in  1  control bits
- mem_stall  in  1  MEM stage cannot take EX/MEM contents
- flush  in  1  external squash (exception/redirect from later stage)
- exmem_valid  out  1  EX/MEM entry valid
- exmem_result  out  DATA_W  ALU result or link address
- exmem_store_data  out  DATA_W  forwarded rs2 value
- exmem_rd  out  RA_W
- exmem_reg_write, exmem_mem_read, exmem_mem_write  out  1  (forced 0 when exmem_valid=0)
- exmem_zero  out  1  result == 0
- redirect  out  1  one-cycle pulse: branch/jump taken
- redirect_pc  out  PC_W  target = id_pc + id_imm (mod 2^PC_W)

Behaviour:
- Reset (async, rst_n=0): all exmem_* = 0, redirect = 0, redirect_pc = 0, state = RUN.
- ex_ready = !exmem_valid | !mem_stall (combinational).
- Accept when id_valid & ex_ready. Latency 1 cycle: the EX/MEM latch updates on the accepting edge.
- Hold: exmem_valid=1 & mem_stall=1 keeps the latch unchanged and redirect = 0.
- Bubble: ex_ready=1 & !id_valid loads exmem_valid=0 and clears all control outputs.
- Arithmetic (all modulo 2^DATA_W):
  - ADD = A+B; SUB = A-B; AND/OR/XOR bitwise; NOT = ~A (B ignored).
  - JUMP result = id_pc+1, zero-extended/truncated to DATA_W.
  - Undefined codes: result = 0, no redirect.
- Taken condition: (id_branch & alu_control==SUB & (A-B)==0) | alu_control==JUMP. When an accepted instruction is taken: redirect=1 for exactly the following cycle, with redirect_pc registered.
- State machine:
  - RUN: a taken accept moves to SQUASH.
  - SQUASH: the next accepted id_valid instruction is converted to a bubble (exmem_valid=0, no redirect), then back to RUN. Non-accepting cycles stay in SQUASH.
- flush=1 has priority over everything except reset: exmem_valid=0, control bits 0, redirect=0, state=RUN. The instruction presented that cycle is discarded. flush with mem_stall: flush wins.
- Reset mid-hold or mid-SQUASH returns to reset values immediately; no pending redirect survives.

Optional Feature:
- Macro: EX_FORWARD_EN.
- Defined: forward exmem_result into A when exmem_valid & exmem_reg_write & !exmem_mem_read & exmem_rd!=0 & exmem_rd==id_rs1. Same rule into B (when id_alu_src=0) and into store data for id_rs2. Forwarding occurs only on accepting cycles.
- Undefined: A/B/store data always come from id_* data. id_rs1/id_rs2 ports remain but are unused.

Test Plan:
- ADD: A=8'hF0, B=8'h20, alu_control=0010 -> next cycle exmem_result=8'h10, exmem_zero=0, exmem_valid=1.
- beq taken: A=B=8'h05, id_branch=1, SUB, id_pc=8'h10, id_imm=8'hFC -> redirect=1 one cycle, redirect_pc=8'h0C. The next accepted instruction yields exmem_valid=0.
- JUMP: id_pc=8'h3F, id_rd=5, id_reg_write=1 -> exmem_result=8'h40, redirect=1, exmem_reg_write=1.
- Stall: exmem_valid=1, mem_stall=1 for 3 cycles with new id_valid -> ex_ready=0, latch unchanged. On release, the new op is accepted in the next cycle.
- Flush during SQUASH with mem_stall=1 -> exmem_valid=0, state RUN. The next instruction (XOR 8'hAA^8'h0F) completes with 8'hA5.
- EX_FORWARD_EN: back-to-back ADD x3=1+2, then ADD x4=x3+x3 with stale id_rs1_data=0 -> 8'h06. Without the macro -> 8'h00.
